// File: rtl/pipe_clk_ctrl_if.sv
// pipe_clk_ctrl_if: debug/control bus between the control side (master) and the pipeline clock-enable controller (slave)
//   div_ratio          enable period minus one
//   run/halt/step_req  one-cycle debug request pulses
//   stall_in           hazard stall, defers the pending enable
//   pipe_ce            one-cycle enable strobe to the pipeline registers
//   step_done          pulse coincident with the pipe_ce of a completed step
//   halted, state      current run state (HALT=00, RUN=01, STEP=10)
//   ce_count           pipe_ce pulses since reset, wraps modulo 2^32
interface pipe_clk_ctrl_if #(parameter int DIV_W = 8);
  logic [DIV_W-1:0] div_ratio;
  logic run_req, halt_req, step_req, stall_in;
  logic pipe_ce, step_done, halted;
  logic [1:0] state;
  logic [31:0] ce_count;
  modport master (output div_ratio, run_req, halt_req, step_req, stall_in,
                  input pipe_ce, step_done, halted, state, ce_count);
  modport slave (input div_ratio, run_req, halt_req, step_req, stall_in,
                 output pipe_ce, step_done, halted, state, ce_count);
endinterface

// File: rtl/pipe_clk_ctrl.sv
// pipe_clk_ctrl: clock-enable controller pacing the pipeline with a divider, hazard stalls and debug run/halt/step
//   clk_in  single system clock
//   rst_n   synchronous active-low reset
//   bus     control/status interface (slave side)
module pipe_clk_ctrl #(
  parameter int DIV_W = 8,
  parameter bit START_RUN = 1'b1
) (
  input logic clk_in,
  input logic rst_n,
  pipe_clk_ctrl_if.slave bus
);
  typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] cnt;
  logic tick, ce_d, done_d;
  // >= rather than == so that lowering div_ratio below cnt ticks at once instead of wrapping
  assign tick = (state_q != HALT) && (cnt >= bus.div_ratio);
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= START_RUN ? RUN : HALT;
      cnt <= '0;
      bus.pipe_ce <= 1'b0;
      bus.step_done <= 1'b0;
      bus.ce_count <= '0;
    end else begin
      state_q <= state_d;
      // cnt holds on a stalled tick so the tick repeats until the stall clears
      cnt <= (state_q == HALT || state_d == HALT) ? '0 :
             tick ? (bus.stall_in ? cnt : '0) : cnt + 1'b1;
      bus.pipe_ce <= ce_d;
      bus.step_done <= done_d;
      bus.ce_count <= bus.ce_count + {31'b0, ce_d};
    end
  end
  always_comb begin
    state_d = bus.halt_req ? HALT :
              state_q == HALT ? (bus.run_req ? RUN : bus.step_req ? STEP : HALT) :
              state_q == RUN ? RUN :
              bus.run_req ? RUN : (tick && !bus.stall_in) ? HALT : STEP;
  end
  always_comb begin
    ce_d = tick && !bus.stall_in && !bus.halt_req;
    done_d = (state_q == STEP) && !bus.run_req && ce_d;
  end
  assign bus.state = state_q;
  assign bus.halted = (state_q == HALT);
endmodule

// File: tb/tb_pipe_clk_ctrl.sv
// tb_pipe_clk_ctrl: directed-vector bench for pipe_clk_ctrl
module tb_pipe_clk_ctrl;
  logic clk, rst_n;
  logic [31:0] ce_m, sd_m;
  int checks, errors;
  pipe_clk_ctrl_if #(.DIV_W(8)) bus ();
  pipe_clk_ctrl #(.DIV_W(8), .START_RUN(1'b1)) dut (.clk_in(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n, input logic [31:0] stall_v, output logic [31:0] ce_o, output logic [31:0] sd_o);
    ce_o = '0;
    sd_o = '0;
    for (int i = 0; i < n; i++) begin
      bus.stall_in = stall_v[i];
      @(negedge clk);
      ce_o[i] = bus.pipe_ce;
      sd_o[i] = bus.step_done;
    end
    bus.stall_in = 1'b0;
  endtask
  task automatic pulse(input logic r, input logic h, input logic s);
    bus.run_req = r;
    bus.halt_req = h;
    bus.step_req = s;
    @(negedge clk);
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.div_ratio = 8'd3;
    bus.run_req = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus.stall_in = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd1);
    chk("rst_ce", 32'(bus.pipe_ce), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_count", bus.ce_count, 32'd0);
    rst_n = 1'b1;
    run(12, 32'h0, ce_m, sd_m);
    chk("run_ce_mask", ce_m, 32'h888);
    chk("run_sd_mask", sd_m, 32'h0);
    chk("run_count", bus.ce_count, 32'd3);
    bus.div_ratio = 8'd2;
    run(9, 32'h1C, ce_m, sd_m);
    chk("stall_ce_mask", ce_m, 32'h120);
    chk("stall_count", bus.ce_count, 32'd5);
    pulse(1'b0, 1'b1, 1'b0);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_state", 32'(bus.state), 32'd0);
    chk("halt_ce", 32'(bus.pipe_ce), 32'd0);
    bus.div_ratio = 8'd1;
    pulse(1'b0, 1'b0, 1'b1);
    chk("step_state1", 32'(bus.state), 32'd2);
    chk("step_halted1", 32'(bus.halted), 32'd0);
    @(negedge clk);
    chk("step_ce2", 32'(bus.pipe_ce), 32'd0);
    chk("step_state2", 32'(bus.state), 32'd2);
    @(negedge clk);
    chk("step_ce3", 32'(bus.pipe_ce), 32'd1);
    chk("step_done3", 32'(bus.step_done), 32'd1);
    chk("step_halted3", 32'(bus.halted), 32'd1);
    chk("step_state3", 32'(bus.state), 32'd0);
    chk("step_count", bus.ce_count, 32'd6);
    @(negedge clk);
    chk("step_ce4", 32'(bus.pipe_ce), 32'd0);
    chk("step_done4", 32'(bus.step_done), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("abort_enter", 32'(bus.state), 32'd2);
    @(negedge clk);
    pulse(1'b1, 1'b1, 1'b0);
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_ce", 32'(bus.pipe_ce), 32'd0);
    chk("abort_done", 32'(bus.step_done), 32'd0);
    chk("abort_count", bus.ce_count, 32'd6);
    bus.div_ratio = 8'd7;
    pulse(1'b1, 1'b0, 1'b1);
    chk("prio_state", 32'(bus.state), 32'd1);
    chk("prio_halted", 32'(bus.halted), 32'd0);
    run(5, 32'h0, ce_m, sd_m);
    chk("ratio7_mask", ce_m, 32'h0);
    bus.div_ratio = 8'd2;
    run(4, 32'h0, ce_m, sd_m);
    chk("ratio2_mask", ce_m, 32'h9);
    chk("ratio_count", bus.ce_count, 32'd8);
    run(2, 32'h0, ce_m, sd_m);
    chk("pre_tick_mask", ce_m, 32'h0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("tick_halt_ce", 32'(bus.pipe_ce), 32'd0);
    chk("tick_halt_halted", 32'(bus.halted), 32'd1);
    chk("tick_halt_cnt", 32'(dut.cnt), 32'd0);
    chk("tick_halt_count", bus.ce_count, 32'd8);
    bus.div_ratio = 8'd0;
    pulse(1'b1, 1'b0, 1'b0);
    chk("div0_enter_ce", 32'(bus.pipe_ce), 32'd0);
    @(negedge clk);
    chk("div0_ce", 32'(bus.pipe_ce), 32'd1);
    chk("div0_count", bus.ce_count, 32'd9);
    force bus.ce_count = 32'hFFFF_FFFE;
    #1 release bus.ce_count;
    @(negedge clk);
    chk("wrap_top", bus.ce_count, 32'hFFFF_FFFF);
    chk("wrap_ce1", 32'(bus.pipe_ce), 32'd1);
    @(negedge clk);
    chk("wrap_zero", bus.ce_count, 32'h0);
    chk("wrap_ce2", 32'(bus.pipe_ce), 32'd1);
    chk("wrap_state", 32'(bus.state), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_ce", 32'(bus.pipe_ce), 32'd0);
    chk("rst2_count", bus.ce_count, 32'd0);
    chk("rst2_done", 32'(bus.step_done), 32'd0);
    chk("rst2_state", 32'(bus.state), 32'd1);
    chk("rst2_halted", 32'(bus.halted), 32'd0);
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
